puf_port_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single PUF read port among NREQ requesters (enrolment generator, reproduction path, self-test).

---
 rtl/fe_pkg.sv | 23 ++
 rtl/rr_pick.sv | 32 +++
 rtl/puf_port_arbiter.sv | 120 ++++++++++++
 tb/tb_puf_port_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fe_pkg.sv
// Shared constants, FSM state encodings and helpers for the PUF front end.
// Used by the PUF port arbiter and its round-robin picker.
package fe_pkg;

  // Reed-Muller code geometry of the fuzzy extractor
  localparam int N = 32;
  localparam int K = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // One-hot of idx within an 8-bit field; out-of-range indices yield 0
  function automatic logic [7:0] onehot(input logic [2:0] idx, input int nreq);
    logic [7:0] v;
    v = '0;
    if (int'(idx) < nreq) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after
// rr_ptr, wrapping modulo NREQ.
module rr_pick
  import fe_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [$clog2(NREQ)-1:0] pick,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ix;

  // Scan from the farthest offset down so the closest hit to rr_ptr wins
  always_comb begin
    pick = '0;
    any  = 1'b0;
    ix   = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      ix = IW'((int'(rr_ptr) + off) % NREQ);
      if (req[ix]) begin
        pick = ix;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/puf_port_arbiter.sv
// Round-robin arbiter sharing the single PUF read port among NREQ requesters.
// Optional abort on a silent PUF: define PUF_ARB_TIMEOUT_EN.
module puf_port_arbiter
  import fe_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int DW      = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] resp_valid,
  output logic [NREQ-1:0] resp_err,
  output logic [DW-1:0]   resp_data,
  output logic            busy,
  output logic            puf_read_req,
  input  logic [DW-1:0]   puf_data,
  input  logic            puf_valid
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("puf_port_arbiter: NREQ must be 2..8 and TIMEOUT >= 1");
  end

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] pick;
  logic [IW-1:0] ptr_next;
  logic          any;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .pick   (pick),
    .any    (any)
  );

  assign ptr_next = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
  assign busy     = (state != S_IDLE);

`ifdef PUF_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] err_q;
  logic            tmo;

  // cnt holds the number of completed S_WAIT cycles before this edge
  assign tmo      = (cnt == CW'(TIMEOUT - 1));
  assign resp_err = err_q;
`else
  assign resp_err = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      grant        <= '0;
      resp_valid   <= '0;
      resp_data    <= '0;
      puf_read_req <= 1'b0;
      rr_ptr       <= '0;
      owner        <= '0;
`ifdef PUF_ARB_TIMEOUT_EN
      cnt          <= '0;
      err_q        <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (any) begin
            grant        <= NREQ'(onehot(3'(pick), NREQ));
            owner        <= pick;
            puf_read_req <= 1'b1;
            state        <= S_WAIT;
`ifdef PUF_ARB_TIMEOUT_EN
            cnt          <= '0;
`endif
          end
        end
        S_WAIT: begin
          // A response arriving on the timeout cycle is still delivered
          if (puf_valid) begin
            resp_data    <= puf_data;
            resp_valid   <= grant;
            puf_read_req <= 1'b0;
            grant        <= '0;
            rr_ptr       <= ptr_next;
            state        <= S_GAP;
          end
`ifdef PUF_ARB_TIMEOUT_EN
          else if (tmo) begin
            err_q        <= grant;
            puf_read_req <= 1'b0;
            grant        <= '0;
            rr_ptr       <= ptr_next;
            state        <= S_GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        S_GAP: begin
          resp_valid <= '0;
`ifdef PUF_ARB_TIMEOUT_EN
          err_q      <= '0;
`endif
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_port_arbiter.sv
// Directed scoreboard bench for puf_port_arbiter (NREQ=2, DW=64, TIMEOUT=4).
// Timeout steps run only when PUF_ARB_TIMEOUT_EN is defined.
module tb_puf_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  grant, resp_valid, resp_err;
  logic [63:0] resp_data;
  logic        busy, puf_read_req;
  logic [63:0] puf_data = '0;
  logic        puf_valid = 1'b0;

  typedef struct {
    logic [1:0]  vm;
    logic [1:0]  em;
    logic [63:0] d;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nmis = 0;

  puf_port_arbiter #(.NREQ(2), .DW(64), .TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .grant        (grant),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_data    (resp_data),
    .busy         (busy),
    .puf_read_req (puf_read_req),
    .puf_data     (puf_data),
    .puf_valid    (puf_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input logic [1:0] og);
    for (int i = 0; i < 20 && puf_read_req !== 1'b1; i++) tick();
    chk("read_req_up", 64'(puf_read_req), 64'd1);
    chk("grant", 64'(grant), 64'(og));
    chk("busy_wait", 64'(busy), 64'd1);
  endtask

  // PUF answers `delay` cycles after puf_read_req rose
  task automatic answer(input logic [1:0] og, input logic [63:0] d, input int delay);
    repeat (delay - 1) tick();
    puf_valid = 1'b1;
    puf_data  = d;
    sb.push_back('{vm: og, em: 2'b00, d: d});
    tick();
    puf_valid = 1'b0;
    puf_data  = '0;
  endtask

  task automatic wait_resp();
    exp_t e;
    for (int i = 0; i < 20 && resp_valid === 2'b00 && resp_err === 2'b00; i++) tick();
    if (sb.size() == 0) begin
      nvec++;
      nmis++;
      $error("FAIL sb_empty: observed response with no expectation queued");
    end else begin
      e = sb.pop_front();
      chk("resp_valid", 64'(resp_valid), 64'(e.vm));
      chk("resp_err", 64'(resp_err), 64'(e.em));
      chk("resp_data", resp_data, e.d);
      chk("grant_released", 64'(grant), 64'd0);
      chk("read_req_down", 64'(puf_read_req), 64'd0);
    end
  endtask

  // One cycle after the response: pulse gone, read request still low
  task automatic gap_check();
    tick();
    chk("pulse_clear", 64'(resp_valid | resp_err), 64'd0);
    chk("gap_read_req", 64'(puf_read_req), 64'd0);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_read_req", 64'(puf_read_req), 64'd0);
    rst = 1'b0;
    tick();

    // Single requester
    req = 2'b01;
    wait_grant(2'b01);
    answer(2'b01, 64'hDEADBEEF_0BADF00D, 2);
    wait_resp();
    req = 2'b00;
    gap_check();
    tick();
    chk("idle_busy", 64'(busy), 64'd0);

    // Contention from reset: alternate 0,1,0,1
    rst = 1'b1;
    req = 2'b11;
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] og;
      og = (k % 2 == 1) ? 2'b10 : 2'b01;
      wait_grant(og);
      answer(og, 64'hA5A5_0000_0000_0000 + 64'(k), 1 + k);
      wait_resp();
      if (k == 3) req = 2'b00;
      gap_check();
    end

    // Requester 1 withdraws mid-transaction, requester 0 is next
    req = 2'b10;
    wait_grant(2'b10);
    req = 2'b01;
    answer(2'b10, 64'h1111_2222_3333_4444, 3);
    wait_resp();
    gap_check();
    wait_grant(2'b01);
    answer(2'b01, 64'h5555_6666_7777_8888, 2);
    wait_resp();
    req = 2'b00;
    gap_check();

    // Stray puf_valid while idle is ignored
    puf_data  = 64'h1234;
    puf_valid = 1'b1;
    tick();
    puf_valid = 1'b0;
    puf_data  = '0;
    chk("stray_data", resp_data, 64'h5555_6666_7777_8888);
    chk("stray_valid", 64'(resp_valid), 64'd0);
    chk("stray_busy", 64'(busy), 64'd0);
    tick();
    chk("stray_grant", 64'(grant), 64'd0);

    // Reset in S_WAIT abandons the transaction; requester 0 wins afterwards
    req = 2'b10;
    wait_grant(2'b10);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_grant", 64'(grant), 64'd0);
    chk("mid_rst_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_err", 64'(resp_err), 64'd0);
    chk("mid_rst_data", resp_data, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_read_req", 64'(puf_read_req), 64'd0);
    rst = 1'b0;
    req = 2'b11;
    wait_grant(2'b01);
    answer(2'b01, 64'hCAFE_F00D_0000_0001, 2);
    wait_resp();
    req = 2'b00;
    gap_check();

`ifdef PUF_ARB_TIMEOUT_EN
    // Silent PUF: abort 4 cycles after grant, data untouched
    req = 2'b10;
    wait_grant(2'b10);
    sb.push_back('{vm: 2'b00, em: 2'b10, d: 64'hCAFE_F00D_0000_0001});
    repeat (3) tick();
    chk("no_early_err", 64'(resp_err), 64'd0);
    tick();
    wait_resp();
    req = 2'b00;
    gap_check();

    // Response on the timeout cycle wins over the abort
    req = 2'b01;
    wait_grant(2'b01);
    answer(2'b01, 64'h0F0F_0F0F_F0F0_F0F0, 4);
    wait_resp();
    req = 2'b00;
    gap_check();
`endif

    if (sb.size() != 0) begin
      nvec++;
      nmis++;
      $error("FAIL sb_leftover: observed %0d pending expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
